// File: rtl/uartlite_tx_sequencer_if.sv
// Wishbone pipelined bus between the TX sequencer (master) and the
// Wishbone-to-AXI4-Lite bridge slave port.
interface uartlite_tx_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_we_o;
  logic [ADDR_W-1:0] wb_addr_o;
  logic [31:0]       wb_data_o;
  logic              wb_stall_i;
  logic              wb_ack_i;
  logic [31:0]       wb_data_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o,
    input  wb_stall_i, wb_ack_i, wb_data_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_data_o,
    output wb_stall_i, wb_ack_i, wb_data_i
  );
endinterface

// File: rtl/uartlite_tx_sequencer.sv
// Byte FIFO plus Wishbone initiator that initialises the AXI UART Lite,
// polls STAT for TX-FIFO-full and writes each buffered byte to TX.
module uartlite_tx_sequencer #(
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                FIFO_DEPTH  = 8,
  parameter int                ACK_TIMEOUT = 256,
  parameter int                POLL_GAP    = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [7:0]              s_data,
  uartlite_tx_sequencer_if.master wb,
  output logic                    busy,
  output logic [15:0]             sent_cnt,
  output logic                    timeout_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TMO_W = $clog2(ACK_TIMEOUT + 1);
  localparam int GAP_W = $clog2(POLL_GAP + 1);

  localparam logic [ADDR_W-1:0] TX_ADDR   = BASE_ADDR + ADDR_W'(32'h4);
  localparam logic [ADDR_W-1:0] STAT_ADDR = BASE_ADDR + ADDR_W'(32'h8);
  localparam logic [ADDR_W-1:0] CTRL_ADDR = BASE_ADDR + ADDR_W'(32'hC);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RD_STAT,
    ST_WAIT,
    ST_WR_TX
  } state_t;

  state_t            state_q, state_d;
  logic              cyc_q, cyc_d;
  logic              stb_q, stb_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [15:0]       sent_q, sent_d;
  logic              terr_q, terr_d;
  logic              en_q;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              push, pop;
  logic              ack_ok, expired;
  logic              start_acc, start_we;
  logic [ADDR_W-1:0] start_addr;
  logic [31:0]       start_data;

  // Only STAT[3] (TX FIFO full) matters to this block.
  logic unused_rdata;
  assign unused_rdata = ^{wb.wb_data_i[31:4], wb.wb_data_i[2:0]};

  // en_q keeps s_ready/busy low while reset is held.
  assign s_ready     = en_q & (count_q != CNT_W'(FIFO_DEPTH));
  assign busy        = en_q & ((state_q != ST_IDLE) | (count_q != '0));
  assign push        = s_valid & s_ready;
  assign sent_cnt    = sent_q;
  assign timeout_err = terr_q;

  assign wb.wb_cyc_o  = cyc_q;
  assign wb.wb_stb_o  = stb_q;
  assign wb.wb_we_o   = we_q;
  assign wb.wb_addr_o = addr_q;
  assign wb.wb_data_o = wdata_q;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= s_data;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    tmo_d      = tmo_q;
    gap_d      = gap_q;
    sent_d     = sent_q;
    terr_d     = terr_q;
    pop        = 1'b0;
    start_acc  = 1'b0;
    start_we   = 1'b0;
    start_addr = '0;
    start_data = '0;

    ack_ok  = cyc_q & wb.wb_ack_i;
    expired = cyc_q & ~wb.wb_ack_i & (tmo_q == TMO_W'(ACK_TIMEOUT - 1));

    // Bus phase tracking shared by every access; the states only decide where to go.
    if (cyc_q) begin
      if (stb_q && !wb.wb_stall_i) stb_d = 1'b0;
      if (ack_ok || expired) begin
        cyc_d = 1'b0;
        stb_d = 1'b0;
      end else begin
        tmo_d = tmo_q + TMO_W'(1);
      end
      if (expired) terr_d = 1'b1;
    end

    case (state_q)
      ST_INIT: begin
        if (!cyc_q) begin
          start_acc  = 1'b1;
          start_we   = 1'b1;
          start_addr = CTRL_ADDR;
          start_data = 32'h0000_0003;
        end else if (ack_ok || expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_IDLE: begin
        if (count_q != '0) state_d = ST_RD_STAT;
      end
      ST_RD_STAT: begin
        if (!cyc_q) begin
          start_acc  = 1'b1;
          start_addr = STAT_ADDR;
        end else if (ack_ok) begin
          state_d = wb.wb_data_i[3] ? ST_WAIT : ST_WR_TX;
          gap_d   = '0;
        end else if (expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (gap_q == GAP_W'(POLL_GAP - 1)) state_d = ST_RD_STAT;
        else                               gap_d   = gap_q + GAP_W'(1);
      end
      ST_WR_TX: begin
        if (!cyc_q) begin
          start_acc  = 1'b1;
          start_we   = 1'b1;
          start_addr = TX_ADDR;
          start_data = {24'h0, mem[rd_ptr_q]};
        end else if (ack_ok) begin
          pop     = 1'b1;
          sent_d  = sent_q + 16'd1;
          state_d = ST_IDLE;
        end else if (expired) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_INIT;
    endcase

    // A state only starts an access while cyc is low, which guarantees an idle gap.
    if (start_acc) begin
      cyc_d   = 1'b1;
      stb_d   = 1'b1;
      we_d    = start_we;
      addr_d  = start_addr;
      wdata_d = start_data;
      tmo_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_INIT;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      tmo_q    <= '0;
      gap_q    <= '0;
      sent_q   <= '0;
      terr_q   <= 1'b0;
      en_q     <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      tmo_q    <= tmo_d;
      gap_q    <= gap_d;
      sent_q   <= sent_d;
      terr_q   <= terr_d;
      en_q     <= 1'b1;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_uartlite_tx_sequencer.sv
// Directed bench for uartlite_tx_sequencer: a scripted Wishbone slave logs
// every accepted access, and tests compare the log against hand-built tables.
`timescale 1ns/1ps
module tb_uartlite_tx_sequencer;
  localparam int          ADDR_W = 32;
  localparam logic [31:0] BASE   = 32'h4060_0000;
  localparam int          DEPTH  = 8;
  localparam int          TMO    = 256;
  localparam int          GAP    = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = 8'h0;
  logic        busy;
  logic [15:0] sent_cnt;
  logic        timeout_err;

  logic        slv_stall = 1'b0;
  logic        slv_ack = 1'b0;
  logic [31:0] slv_rdata = 32'h0;

  always #5 clk = ~clk;

  uartlite_tx_sequencer_if #(.ADDR_W(ADDR_W)) bus ();
  assign bus.wb_stall_i = slv_stall;
  assign bus.wb_ack_i   = slv_ack;
  assign bus.wb_data_i  = slv_rdata;

  uartlite_tx_sequencer #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH),
    .ACK_TIMEOUT(TMO), .POLL_GAP(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .wb(bus), .busy(busy), .sent_cnt(sent_cnt),
    .timeout_err(timeout_err)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc_at;
    int          stb_len;
    bit          unstable;
  } acc_t;

  acc_t log_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle_num = 0;
  int   last_cyc_len = 0;
  int   proto_err = 0;
  int   stall_cfg = 0;
  bit   hold_stall = 0;
  bit   no_ack_wr = 0;
  int   stat_full_left = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%08h", name, act);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cycle_num++;
  end

  // Scripted slave: decides stall/ack at each negedge for the following posedge.
  initial begin : slave
    bit   pend = 0, pend_we = 0, in_req = 0, acc_prev = 0, ack_prev = 0;
    int   stall_left = 0, stb_len = 0;
    acc_t cur;
    cur = '{we: 1'b0, addr: 32'h0, data: 32'h0, cyc_at: 0, stb_len: 0, unstable: 1'b0};
    forever begin
      @(negedge clk);
      if (acc_prev && bus.wb_stb_o) proto_err++;
      if (ack_prev && bus.wb_cyc_o) proto_err++;
      acc_prev  = 0;
      slv_ack   = 1'b0;
      slv_rdata = 32'h0;
      slv_stall = 1'b0;
      if (!rst_n) begin
        pend = 0;
        in_req = 0;
      end else begin
        if (pend) begin
          pend = 0;
          if (!(pend_we && no_ack_wr)) begin
            slv_ack = 1'b1;
            if (!pend_we) begin
              slv_rdata = (stat_full_left > 0) ? 32'h8 : 32'h4;
              if (stat_full_left > 0) stat_full_left--;
            end
          end
        end
        if (bus.wb_stb_o) begin
          if (!in_req) begin
            in_req = 1;
            stall_left = stall_cfg;
            stb_len = 0;
            cur.we = bus.wb_we_o;
            cur.addr = bus.wb_addr_o;
            cur.data = bus.wb_data_o;
            cur.cyc_at = cycle_num;
            cur.unstable = 0;
          end else if (cur.we !== bus.wb_we_o || cur.addr !== bus.wb_addr_o ||
                       cur.data !== bus.wb_data_o) begin
            cur.unstable = 1;
          end
          stb_len++;
          if (hold_stall || stall_left > 0) begin
            slv_stall = 1'b1;
            if (stall_left > 0) stall_left--;
          end else begin
            pend = 1;
            pend_we = cur.we;
            acc_prev = 1;
            cur.stb_len = stb_len;
            log_q.push_back(cur);
          end
        end
        if (!bus.wb_cyc_o) in_req = 0;
      end
      ack_prev = slv_ack;
    end
  end

  initial begin : cycmon
    int run = 0;
    forever begin
      @(negedge clk);
      if (bus.wb_cyc_o) run++;
      else begin
        if (run > 0) last_cyc_len = run;
        run = 0;
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b);
    int t = 0;
    while (!s_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) chk("push_ready_timeout", {31'h0, s_ready}, 32'h1);
    s_data = b;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int t = 0;
    while (busy && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (t >= limit) chk(name, {31'h0, busy}, 32'h0);
  endtask

  function automatic int count_writes();
    int n = 0;
    foreach (log_q[k]) if (log_q[k].we) n++;
    return n;
  endfunction

  typedef struct {
    logic [7:0]  b;
    int          n_full;
    logic [15:0] exp_sent;
  } vec_t;

  vec_t vecs[4];
  logic [7:0] wr_bytes[$];

  initial begin
    int t;
    vecs[0] = '{b: 8'hAF, n_full: 0, exp_sent: 16'd1};
    vecs[1] = '{b: 8'h55, n_full: 3, exp_sent: 16'd2};
    vecs[2] = '{b: 8'h00, n_full: 1, exp_sent: 16'd3};
    vecs[3] = '{b: 8'hFF, n_full: 0, exp_sent: 16'd4};

    // T1: reset
    tick(3);
    chk("rst_cyc", {31'h0, bus.wb_cyc_o}, 32'h0);
    chk("rst_stb", {31'h0, bus.wb_stb_o}, 32'h0);
    chk("rst_we", {31'h0, bus.wb_we_o}, 32'h0);
    chk("rst_addr", bus.wb_addr_o, 32'h0);
    chk("rst_data", bus.wb_data_o, 32'h0);
    chk("rst_s_ready", {31'h0, s_ready}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_sent", {16'h0, sent_cnt}, 32'h0);
    chk("rst_terr", {31'h0, timeout_err}, 32'h0);
    rst_n = 1'b1;
    t = 0;
    while (log_q.size() == 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("init_seen", log_q.size(), 1);
    if (log_q.size() >= 1) begin
      chk("init_we", {31'h0, log_q[0].we}, 32'h1);
      chk("init_addr", log_q[0].addr, BASE + 32'hC);
      chk("init_data", log_q[0].data, 32'h3);
    end
    wait_idle("init_idle_timeout", 100);
    chk("post_init_s_ready", {31'h0, s_ready}, 32'h1);
    chk("post_init_busy", {31'h0, busy}, 32'h0);

    // T2/T3: table of single bytes with varying STAT-full polls
    for (int i = 0; i < 4; i++) begin
      log_q.delete();
      stat_full_left = vecs[i].n_full;
      push_byte(vecs[i].b);
      wait_idle("vec_idle_timeout", 3000);
      chk($sformatf("vec%0d_naccess", i), log_q.size(), vecs[i].n_full + 2);
      if (log_q.size() == vecs[i].n_full + 2) begin
        for (int j = 0; j <= vecs[i].n_full; j++) begin
          chk($sformatf("vec%0d_rd%0d_we", i, j), {31'h0, log_q[j].we}, 32'h0);
          chk($sformatf("vec%0d_rd%0d_addr", i, j), log_q[j].addr, BASE + 32'h8);
          if (j > 0)
            chk($sformatf("vec%0d_rd%0d_gap_ok", i, j),
                {31'h0, (log_q[j].cyc_at - log_q[j-1].cyc_at) >= GAP}, 32'h1);
        end
        chk($sformatf("vec%0d_wr_we", i), {31'h0, log_q[vecs[i].n_full+1].we}, 32'h1);
        chk($sformatf("vec%0d_wr_addr", i), log_q[vecs[i].n_full+1].addr, BASE + 32'h4);
        chk($sformatf("vec%0d_wr_data", i), log_q[vecs[i].n_full+1].data, {24'h0, vecs[i].b});
      end
      chk($sformatf("vec%0d_sent", i), {16'h0, sent_cnt}, {16'h0, vecs[i].exp_sent});
      chk($sformatf("vec%0d_busy", i), {31'h0, busy}, 32'h0);
    end

    // T4: five stall cycles per access
    log_q.delete();
    stall_cfg = 5;
    push_byte(8'h3C);
    wait_idle("bp_idle_timeout", 500);
    stall_cfg = 0;
    chk("bp_naccess", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("bp_rd_stb_len", log_q[0].stb_len, 6);
      chk("bp_wr_stb_len", log_q[1].stb_len, 6);
      chk("bp_wr_stable", {31'h0, log_q[1].unstable}, 32'h0);
      chk("bp_wr_data", log_q[1].data, 32'h3C);
    end
    chk("bp_sent", {16'h0, sent_cnt}, 32'd5);

    // T5: fill the FIFO while the slave stalls
    log_q.delete();
    hold_stall = 1;
    for (int i = 0; i < DEPTH; i++) push_byte(8'h10 + 8'(i));
    chk("full_s_ready", {31'h0, s_ready}, 32'h0);
    s_data = 8'hEE;
    s_valid = 1'b1;
    tick(3);
    chk("full_s_ready_hold", {31'h0, s_ready}, 32'h0);
    s_valid = 1'b0;
    hold_stall = 0;
    wait_idle("full_idle_timeout", 4000);
    wr_bytes.delete();
    foreach (log_q[k]) if (log_q[k].we) wr_bytes.push_back(log_q[k].data[7:0]);
    chk("full_nwrites", wr_bytes.size(), DEPTH);
    foreach (wr_bytes[k]) chk($sformatf("full_byte%0d", k), {24'h0, wr_bytes[k]}, 32'h10 + k);
    chk("full_sent", {16'h0, sent_cnt}, 32'd13);
    chk("proto_ok", proto_err, 0);

    // T6: TX write never acked
    log_q.delete();
    no_ack_wr = 1;
    push_byte(8'h77);
    t = 0;
    while (!timeout_err && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) chk("tmo_wait_timeout", {31'h0, timeout_err}, 32'h1);
    tick(2);
    chk("tmo_cyc_len", last_cyc_len, TMO);
    chk("tmo_err", {31'h0, timeout_err}, 32'h1);
    chk("tmo_sent", {16'h0, sent_cnt}, 32'd13);
    chk("tmo_busy", {31'h0, busy}, 32'h1);
    t = 0;
    while (count_writes() < 2 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("tmo_retry_writes", count_writes(), 2);
    if (log_q.size() > 0) chk("tmo_retry_data", log_q[log_q.size()-1].data, 32'h77);
    chk("tmo_retry_cyc", {31'h0, bus.wb_cyc_o}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cyc", {31'h0, bus.wb_cyc_o}, 32'h0);
    chk("arst_stb", {31'h0, bus.wb_stb_o}, 32'h0);
    chk("arst_terr", {31'h0, timeout_err}, 32'h0);
    chk("arst_sent", {16'h0, sent_cnt}, 32'h0);
    chk("arst_s_ready", {31'h0, s_ready}, 32'h0);
    @(negedge clk);
    no_ack_wr = 0;
    log_q.delete();
    tick(2);
    rst_n = 1'b1;
    tick(1);
    wait_idle("arst_idle_timeout", 200);
    chk("arst_naccess", log_q.size(), 1);
    chk("arst_post_sent", {16'h0, sent_cnt}, 32'h0);
    chk("proto_ok_end", proto_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
